csa_adder_32: RTL and testbench

- Registered n-bit carry-select adder, 32 bits by default.
- Computes {cout, s} = a + b + cin with a blocked carry-select structure, then registers the result on the rising edge of clk.
- Serves as a datapath adder and as the implementation under comparison against the behavioural golden adder in the adder-evaluation flow. It shares that flow's cin/a/b/s/cout port contract.
- Provides no propagate/generate outputs (adder class "type 0": same class as ripple and carry-select variants).

---
 rtl/csa_adder_32.sv | 114 +++++++++++
 tb/tb_csa_adder_32.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/csa_adder_32.sv
// ---------------------------------------------------------------------------
// csa_adder_32
// Registered n-bit carry-select adder. The operands are split into BLK-bit
// blocks. Block 0 ripples directly from cin. Every later block pre-computes
// its sum and carry twice, once assuming a carry in of 0 and once assuming 1.
// The real incoming carry then picks one of the two results through a 2:1 mux.
// The full result {cout, s} = a + b + cin is registered on each rising clk
// edge, so the latency is one cycle.
//
// Parameters
//   n    : operand / sum width, a positive multiple of BLK (default 32)
//   BLK  : carry-select block width (default 4)
//
// Ports
//   clk   in   1  rising-edge clock
//   rst_n in   1  asynchronous active-low reset, clears s and cout
//   cin   in   1  carry in
//   a     in   n  operand A, unsigned
//   b     in   n  operand B, unsigned
//   s     out  n  registered sum, bits n-1..0 of a+b+cin
//   cout  out  1  registered carry out, bit n of a+b+cin
// ---------------------------------------------------------------------------
module csa_adder_32 #(
    parameter int n   = 32,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] s,
    output logic         cout
);

    localparam int NBLK = n / BLK;

    // A width that does not split into whole blocks is a configuration
    // error. Stop elaboration instead of building a partial adder.
    generate
        if ((n <= 0) || (BLK <= 0) || ((n % BLK) != 0)) begin : g_cfgError
            $error("csa_adder_32: n (%0d) must be a positive multiple of BLK (%0d)", n, BLK);
        end
    endgenerate

    // w_carry[k] is the carry into block k.
    // w_carry[NBLK] is the carry out of the whole adder.
    logic [NBLK:0] w_carry;
    logic [n-1:0]  w_sum;

    assign w_carry[0] = cin;

    generate
        for (genvar k = 0; k < NBLK; k++) begin : g_blk
            if (k == 0) begin : g_ripple
                // The first block has the real carry in available at once,
                // so it is a plain ripple adder with no duplicate.
                logic [BLK:0] w_c;
                assign w_c[0] = w_carry[0];
                for (genvar i = 0; i < BLK; i++) begin : g_bit
                    logic w_x;
                    logic w_y;
                    assign w_x        = a[k*BLK + i];
                    assign w_y        = b[k*BLK + i];
                    assign w_sum[k*BLK + i] = w_x ^ w_y ^ w_c[i];
                    assign w_c[i+1]   = (w_x & w_y) | (w_c[i] & (w_x ^ w_y));
                end
                assign w_carry[k+1] = w_c[BLK];
            end else begin : g_select
                // Two speculative ripple chains run in parallel. The incoming
                // block carry only drives the muxes, so the carry path
                // between blocks is a chain of muxes, not a chain of adders.
                logic [BLK:0]   w_c0;
                logic [BLK:0]   w_c1;
                logic [BLK-1:0] w_s0;
                logic [BLK-1:0] w_s1;
                assign w_c0[0] = 1'b0;
                assign w_c1[0] = 1'b1;
                for (genvar i = 0; i < BLK; i++) begin : g_bit
                    logic w_x;
                    logic w_y;
                    assign w_x       = a[k*BLK + i];
                    assign w_y       = b[k*BLK + i];
                    assign w_s0[i]   = w_x ^ w_y ^ w_c0[i];
                    assign w_c0[i+1] = (w_x & w_y) | (w_c0[i] & (w_x ^ w_y));
                    assign w_s1[i]   = w_x ^ w_y ^ w_c1[i];
                    assign w_c1[i+1] = (w_x & w_y) | (w_c1[i] & (w_x ^ w_y));
                end
                assign w_sum[k*BLK +: BLK] = w_carry[k] ? w_s1 : w_s0;
                assign w_carry[k+1]        = w_carry[k] ? w_c1[BLK] : w_c0[BLK];
            end
        end
    endgenerate

    // Output register.
    // Reset clears the result asynchronously and takes priority over a
    // coincident clock edge.
    logic [n-1:0] r_s;
    logic         r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_carry[NBLK];
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

endmodule

// File: tb/tb_csa_adder_32.sv
// ---------------------------------------------------------------------------
// tb_csa_adder_32
// Self-checking bench for csa_adder_32. It instantiates the default 32-bit
// adder plus 16-bit, 8-bit and single-block (n = BLK = 4) variants.
// The inputs of each instance are driven right after a rising edge. The
// registered outputs are read 1 time unit after the following rising edge.
// Expected values come from hand-computed directed vectors and from
// behavioural a + b + cin.
// ---------------------------------------------------------------------------
module tb_csa_adder_32;

    logic        clk;
    logic        rst_n;
    logic        cin;
    logic [31:0] a32, b32, s32;
    logic [15:0] a16, b16, s16;
    logic [7:0]  a8,  b8,  s8;
    logic [3:0]  a4,  b4,  s4;
    logic        cout32, cout16, cout8, cout4;

    int assertCount = 0;
    int failCount   = 0;

    csa_adder_32 #(.n(32), .BLK(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .cin(cin), .a(a32), .b(b32), .s(s32), .cout(cout32)
    );
    csa_adder_32 #(.n(16), .BLK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .cin(cin), .a(a16), .b(b16), .s(s16), .cout(cout16)
    );
    csa_adder_32 #(.n(8), .BLK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .cin(cin), .a(a8), .b(b8), .s(s8), .cout(cout8)
    );
    csa_adder_32 #(.n(4), .BLK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cin(cin), .a(a4), .b(b4), .s(s4), .cout(cout4)
    );

    // Free-running clock with a 10-unit period. Rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. Values are {cout, s}, zero-extended.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive the 32-bit operands and wait for them to be registered.
    task automatic applyStimulus(input logic c, input logic [31:0] x, input logic [31:0] y);
        cin = c;
        a32 = x;
        b32 = y;
        @(posedge clk);
        #1;
    endtask

    task automatic runVector(input string tag, input logic c, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] expS,
                             input logic expCout);
        applyStimulus(c, x, y);
        checkOutput(tag, {31'd0, cout32, s32}, {31'd0, expCout, expS});
    endtask

    initial begin
        logic [32:0] exp32;
        logic [16:0] exp16;
        logic [8:0]  exp8;
        logic [4:0]  exp4;

        rst_n = 1'b0;
        cin   = 1'b0;
        a32 = '0; b32 = '0;
        a16 = '0; b16 = '0;
        a8  = '0; b8  = '0;
        a4  = '0; b4  = '0;

        // Outputs must be cleared while reset is held.
        #3;
        checkOutput("resetState", {31'd0, cout32, s32}, 64'd0);
        checkOutput("resetState16", {47'd0, cout16, s16}, 64'd0);

        // Release reset away from any edge, then load a nonzero result.
        #4 rst_n = 1'b1;
        runVector("preReset", 1'b0, 32'd5, 32'd3, 32'd8, 1'b0);

        // Reset asserted mid-cycle must clear the outputs with no clock edge.
        #2;
        rst_n = 1'b0;
        a32 = 32'hFFFF_FFFF;
        b32 = 32'd1;
        cin = 1'b0;
        #1;
        checkOutput("asyncReset", {31'd0, cout32, s32}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("resetHold", {31'd0, cout32, s32}, 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("firstAfterReset", {31'd0, cout32, s32}, {31'd0, 1'b1, 32'd0});

        // Directed vectors for the 32-bit adder.
        runVector("zero",        1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        runVector("cinOnly",     1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0);
        runVector("fullProp",    1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1);
        runVector("msbCarry",    1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        runVector("blk0Carry",   1'b0, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0);
        runVector("blkMidCarry", 1'b1, 32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0001, 1'b0);
        runVector("maxOperands", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        runVector("altBits",     1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0);
        runVector("msbOverflow", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
        runVector("mixed",       1'b0, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0);
        runVector("oddBlocks",   1'b1, 32'h00F0_0F0F, 32'h000F_00F0, 32'h00FF_1000, 1'b0);

        // Directed vectors for the narrower variants.
        cin = 1'b0;
        a16 = 16'h0FFF; b16 = 16'h0001;
        a8  = 8'hFF;    b8  = 8'h01;
        a4  = 4'hF;     b4  = 4'hF;
        @(posedge clk);
        #1;
        checkOutput("n16Boundary", {47'd0, cout16, s16}, {47'd0, 1'b0, 16'h1000});
        checkOutput("n8Wrap",      {55'd0, cout8, s8},   {55'd0, 1'b1, 8'h00});
        checkOutput("n4Single",    {59'd0, cout4, s4},   {59'd0, 1'b1, 4'hE});

        // Random regression. Inputs change just after an edge and are checked
        // after the next edge against the behavioural sum.
        for (int i = 0; i < 30000; i++) begin
            cin = 1'($urandom);
            a32 = $urandom;
            b32 = $urandom;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            exp32 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin};
            exp16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin};
            exp8  = {1'b0, a8}  + {1'b0, b8}  + {8'd0, cin};
            exp4  = {1'b0, a4}  + {1'b0, b4}  + {4'd0, cin};
            @(posedge clk);
            #1;
            checkOutput("rand32", {31'd0, cout32, s32}, {31'd0, exp32});
            checkOutput("rand16", {47'd0, cout16, s16}, {47'd0, exp16});
            checkOutput("rand8",  {55'd0, cout8, s8},   {55'd0, exp8});
            checkOutput("rand4",  {59'd0, cout4, s4},   {59'd0, exp4});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
